// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: tracks in-flight register writes, stalls on RAW hazards,
// inserts bubbles on stall/flush and drains the pipeline after HALT.
module hazard_scoreboard #(
    parameter int unsigned DEPTH     = 3,
    parameter int unsigned WB_BYPASS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        idValid,
    input  logic        useRs,
    input  logic        useRt,
    input  logic [2:0]  read1Sel,
    input  logic [2:0]  read2Sel,
    input  logic        regWrt,
    input  logic [2:0]  writeReg,
    input  logic        idHalt,
    input  logic        flush,
    output logic        stall,
    output logic        bubble,
    output logic        haltDone,
    output logic [15:0] stallCnt,
    output logic        err
);

    // With bypass the register file forwards the WB write, so the last slot is never a hazard.
    localparam int unsigned NumChecked = (WB_BYPASS != 0) ? DEPTH - 1 : DEPTH;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StDrain  = 2'd1,
        StHalted = 2'd2,
        StBad    = 2'd3
    } state_e;

    state_e           stateQ;
    logic [2:0]       drainCntQ;
    logic [15:0]      stallCntQ;
    logic             haltDoneQ;
    logic [DEPTH-1:0] slotVQ;
    logic [2:0]       slotDstQ [DEPTH];

    logic isRun;
    logic hz;
    logic advance;
    logic slot0V;

    assign isRun = (stateQ == StRun);

    always_comb begin
        hz = 1'b0;
        for (int i = 0; i < int'(NumChecked); i++) begin
            if (slotVQ[i] && ((useRs && (slotDstQ[i] == read1Sel)) ||
                              (useRt && (slotDstQ[i] == read2Sel)))) begin
                hz = 1'b1;
            end
        end
        hz = hz & idValid & isRun & ~flush;
    end

    assign advance = idValid & isRun & ~hz & ~flush;
    // HALT enters the pipeline as a non-writing entry.
    assign slot0V  = advance & regWrt & ~idHalt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slotVQ <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                slotDstQ[i] <= 3'd0;
            end
        end else begin
            slotVQ      <= {slotVQ[DEPTH-2:0], slot0V};
            slotDstQ[0] <= advance ? writeReg : 3'd0;
            for (int i = 1; i < int'(DEPTH); i++) begin
                slotDstQ[i] <= slotDstQ[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ    <= StRun;
            drainCntQ <= 3'd0;
            stallCntQ <= 16'd0;
            haltDoneQ <= 1'b0;
        end else begin
            if (hz && (stallCntQ != 16'hFFFF)) begin
                stallCntQ <= stallCntQ + 16'd1;
            end
            case (stateQ)
                StRun: begin
                    if (advance && idHalt) begin
                        stateQ    <= StDrain;
                        drainCntQ <= 3'(DEPTH);
                    end
                end
                StDrain: begin
                    drainCntQ <= drainCntQ - 3'd1;
                    if (drainCntQ <= 3'd1) begin
                        stateQ    <= StHalted;
                        haltDoneQ <= 1'b1;
                    end
                end
                StHalted: begin
                    haltDoneQ <= 1'b1;
                end
                default: begin
                    stateQ    <= StHalted;
                    haltDoneQ <= 1'b1;
                end
            endcase
        end
    end

    assign stall    = isRun ? hz : 1'b1;
    assign bubble   = isRun ? (hz | flush) : 1'b1;
    assign haltDone = haltDoneQ;
    assign stallCnt = stallCntQ;
    assign err      = (stateQ == StBad);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: a bypassing and a non-bypassing instance share one input set.
module tb_hazard_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        idValid, useRs, useRt, regWrt, idHalt, flush;
    logic [2:0]  read1Sel, read2Sel, writeReg;
    logic [1:0]  stallV, bubbleV, doneV, errV;
    logic [15:0] cntV [2];

    int nCmp = 0;
    int nErr = 0;

    hazard_scoreboard #(.DEPTH(3), .WB_BYPASS(1)) dutA (
        .clk(clk), .rst(rst), .idValid(idValid), .useRs(useRs), .useRt(useRt),
        .read1Sel(read1Sel), .read2Sel(read2Sel), .regWrt(regWrt), .writeReg(writeReg),
        .idHalt(idHalt), .flush(flush), .stall(stallV[0]), .bubble(bubbleV[0]),
        .haltDone(doneV[0]), .stallCnt(cntV[0]), .err(errV[0])
    );

    hazard_scoreboard #(.DEPTH(3), .WB_BYPASS(0)) dutB (
        .clk(clk), .rst(rst), .idValid(idValid), .useRs(useRs), .useRt(useRt),
        .read1Sel(read1Sel), .read2Sel(read2Sel), .regWrt(regWrt), .writeReg(writeReg),
        .idHalt(idHalt), .flush(flush), .stall(stallV[1]), .bubble(bubbleV[1]),
        .haltDone(doneV[1]), .stallCnt(cntV[1]), .err(errV[1])
    );

    task automatic drive(input logic v, input logic rs, input logic [2:0] r1, input logic rt,
                         input logic [2:0] r2, input logic wr, input logic [2:0] wd,
                         input logic halt, input logic fl);
        idValid = v;  useRs = rs; read1Sel = r1; useRt = rt; read2Sel = r2;
        regWrt  = wr; writeReg = wd; idHalt = halt; flush = fl;
    endtask

    task automatic doReset();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        nCmp++; if (stallV !== 2'b00) begin nErr++; $display("FAIL reset_stall got %b want 00", stallV); end
        nCmp++; if (bubbleV !== 2'b00) begin nErr++; $display("FAIL reset_bubble got %b want 00", bubbleV); end
        nCmp++; if (doneV !== 2'b00) begin nErr++; $display("FAIL reset_done got %b want 00", doneV); end
        nCmp++; if (errV !== 2'b00) begin nErr++; $display("FAIL reset_err got %b want 00", errV); end
        nCmp++; if (cntV[0] !== 16'd0 || cntV[1] !== 16'd0) begin
            nErr++; $display("FAIL reset_cnt got %0h/%0h want 0/0", cntV[0], cntV[1]);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp;
        doReset();
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 1, 3, 0, 0);
        #1;
        nCmp++; if (stallV !== 2'b00) begin nErr++; $display("FAIL b2b_producer got %b want 00", stallV); end
        // Consumer held in ID: 2 stall cycles with bypass, 3 without.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(1, 1, 3, 0, 0, 0, 0, 0, 0);
            #1;
            exp = {1'(k < 3), 1'(k < 2)};
            nCmp++; if (stallV !== exp) begin nErr++; $display("FAIL b2b_stall[%0d] got %b want %b", k, stallV, exp); end
            nCmp++; if (bubbleV !== exp) begin nErr++; $display("FAIL b2b_bubble[%0d] got %b want %b", k, bubbleV, exp); end
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        nCmp++; if (cntV[0] !== 16'd2 || cntV[1] !== 16'd3) begin
            nErr++; $display("FAIL b2b_cnt got %0d/%0d want 2/3", cntV[0], cntV[1]);
        end
    endtask

    task automatic test_independent();
        doReset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0)      drive(1, 0, 0, 0, 0, 1, 3, 0, 0);
            else if (k == 1) drive(1, 1, 4, 1, 5, 0, 0, 0, 0);
            else             drive(1, 1, 4, 0, 3, 0, 0, 0, 0);
            #1;
            nCmp++; if (stallV !== 2'b00) begin nErr++; $display("FAIL indep_stall[%0d] got %b want 00", k, stallV); end
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        nCmp++; if (cntV[0] !== 16'd0 || cntV[1] !== 16'd0) begin
            nErr++; $display("FAIL indep_cnt got %0d/%0d want 0/0", cntV[0], cntV[1]);
        end
    endtask

    task automatic test_flush_hazard();
        doReset();
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 1, 3, 0, 0);
        @(negedge clk);
        drive(1, 1, 3, 0, 0, 1, 6, 0, 1);
        #1;
        nCmp++; if (stallV !== 2'b00) begin nErr++; $display("FAIL flush_stall got %b want 00", stallV); end
        nCmp++; if (bubbleV !== 2'b11) begin nErr++; $display("FAIL flush_bubble got %b want 11", bubbleV); end
        // The squashed writer of r6 must not have been recorded.
        @(negedge clk);
        drive(1, 1, 6, 0, 0, 0, 0, 0, 0);
        #1;
        nCmp++; if (stallV !== 2'b00) begin nErr++; $display("FAIL flush_slot0 got %b want 00", stallV); end
        nCmp++; if (bubbleV !== 2'b00) begin nErr++; $display("FAIL flush_nobubble got %b want 00", bubbleV); end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        nCmp++; if (cntV[0] !== 16'd0 || cntV[1] !== 16'd0) begin
            nErr++; $display("FAIL flush_cnt got %0d/%0d want 0/0", cntV[0], cntV[1]);
        end
    endtask

    task automatic test_halt();
        doReset();
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 1, 2, 1, 0);
        #1;
        nCmp++; if (stallV !== 2'b00 || bubbleV !== 2'b00 || doneV !== 2'b00) begin
            nErr++; $display("FAIL halt_issue got s%b b%b d%b want 00/00/00", stallV, bubbleV, doneV);
        end
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            drive(1'($urandom), 1, 2, 1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom),
                  1'($urandom), 1'($urandom));
            #1;
            nCmp++; if (stallV !== 2'b11 || bubbleV !== 2'b11) begin
                nErr++; $display("FAIL halt_drain_sb[%0d] got s%b b%b want 11/11", k, stallV, bubbleV);
            end
            nCmp++; if (doneV !== ((k < 3) ? 2'b00 : 2'b11)) begin
                nErr++; $display("FAIL halt_done[%0d] got %b want %b", k, doneV, (k < 3) ? 2'b00 : 2'b11);
            end
        end
        nCmp++; if (cntV[0] !== 16'd0 || cntV[1] !== 16'd0 || errV !== 2'b00) begin
            nErr++; $display("FAIL halt_cnt got %0d/%0d err %b want 0/0 err 00", cntV[0], cntV[1], errV);
        end
    endtask

    task automatic test_reset_mid_drain();
        doReset();
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 1, 3, 0, 0);
        repeat (3) begin
            @(negedge clk);
            drive(1, 1, 3, 0, 0, 0, 0, 0, 0);
        end
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        nCmp++; if (cntV[0] !== 16'd2 || cntV[1] !== 16'd3 || stallV !== 2'b11) begin
            nErr++; $display("FAIL mid_pre got %0d/%0d s%b want 2/3 s11", cntV[0], cntV[1], stallV);
        end
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        nCmp++; if (stallV !== 2'b00 || bubbleV !== 2'b00 || doneV !== 2'b00 || errV !== 2'b00) begin
            nErr++; $display("FAIL mid_outs got s%b b%b d%b e%b want 00", stallV, bubbleV, doneV, errV);
        end
        nCmp++; if (cntV[0] !== 16'd0 || cntV[1] !== 16'd0) begin
            nErr++; $display("FAIL mid_cnt got %0d/%0d want 0/0", cntV[0], cntV[1]);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 1, 5, 0, 0);
        @(negedge clk);
        drive(1, 0, 0, 1, 5, 0, 0, 0, 0);
        #1;
        nCmp++; if (stallV !== 2'b11) begin nErr++; $display("FAIL mid_restall got %b want 11", stallV); end
        repeat (3) @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        nCmp++; if (cntV[0] !== 16'd2 || cntV[1] !== 16'd3) begin
            nErr++; $display("FAIL mid_recnt got %0d/%0d want 2/3", cntV[0], cntV[1]);
        end
    endtask

    task automatic test_saturation();
        doReset();
        @(negedge clk);
        force dutA.stallCntQ = 16'hFFFE;
        force dutB.stallCntQ = 16'hFFFE;
        #1;
        release dutA.stallCntQ;
        release dutB.stallCntQ;
        #1;
        nCmp++; if (cntV[0] !== 16'hFFFE || cntV[1] !== 16'hFFFE) begin
            nErr++; $display("FAIL sat_preload got %0h/%0h want fffe/fffe", cntV[0], cntV[1]);
        end
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 1, 3, 0, 0);
        // Each consumer also rewrites r3, so hazards keep recurring.
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            drive(1, 1, 3, 0, 0, 1, 3, 0, 0);
            #1;
            if (k == 2) begin
                nCmp++; if (cntV[0] !== 16'hFFFF || cntV[1] !== 16'hFFFF) begin
                    nErr++; $display("FAIL sat_mid got %0h/%0h want ffff/ffff", cntV[0], cntV[1]);
                end
            end
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        nCmp++; if (cntV[0] !== 16'hFFFF || cntV[1] !== 16'hFFFF) begin
            nErr++; $display("FAIL sat_end got %0h/%0h want ffff/ffff", cntV[0], cntV[1]);
        end
    endtask

    // Reference: a writer that left ID n cycles ago blocks readers while n <= checked depth.
    task automatic test_random();
        logic [3:0] hist [2][512];
        int         expCnt [2];
        int         nChk [2];
        logic       expHz;
        logic [3:0] h;
        nChk = '{2, 3};
        expCnt = '{0, 0};
        for (int m = 0; m < 2; m++) for (int t = 0; t < 512; t++) hist[m][t] = 4'd0;
        doReset();
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 3'($urandom_range(0, 3)),
                  1'($urandom), 3'($urandom_range(0, 3)), 1'($urandom),
                  3'($urandom_range(0, 3)), 1'b0, 1'($urandom_range(0, 7) == 0));
            #1;
            for (int m = 0; m < 2; m++) begin
                expHz = 1'b0;
                for (int a = 1; a <= nChk[m]; a++) begin
                    if (t - a >= 0) begin
                        h = hist[m][t-a];
                        if (h[3] && ((useRs && h[2:0] == read1Sel) || (useRt && h[2:0] == read2Sel)))
                            expHz = 1'b1;
                    end
                end
                expHz = expHz & idValid & ~flush;
                nCmp++; if (stallV[m] !== expHz) begin
                    nErr++; $display("FAIL rnd_stall dut%0d t%0d got %b want %b", m, t, stallV[m], expHz);
                end
                nCmp++; if (bubbleV[m] !== (expHz | flush)) begin
                    nErr++; $display("FAIL rnd_bubble dut%0d t%0d got %b want %b", m, t, bubbleV[m], expHz | flush);
                end
                nCmp++; if (cntV[m] !== 16'(expCnt[m])) begin
                    nErr++; $display("FAIL rnd_cnt dut%0d t%0d got %0d want %0d", m, t, cntV[m], expCnt[m]);
                end
                nCmp++; if (doneV[m] !== 1'b0 || errV[m] !== 1'b0) begin
                    nErr++; $display("FAIL rnd_done_err dut%0d t%0d got %b%b want 00", m, t, doneV[m], errV[m]);
                end
                hist[m][t] = {idValid & ~expHz & ~flush & regWrt, writeReg};
                if (expHz && expCnt[m] < 65535) expCnt[m]++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_independent();
        test_flush_hazard();
        test_halt();
        test_reset_mid_drain();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
